pac_dir_buffer: RTL and testbench

- Upstream stage of the player motion block: turns raw USB keycodes into the single held keycode that the motion block consumes.
- Debounces key changes over frame ticks and buffers one pending turn, Pac-Man style.
- Commits the pending turn only when the maze/tile logic reports the turn is legal, or when it is a reversal.
- Keeps the last committed direction after the key is released, so the player keeps moving.

---
 rtl/pac_pkg.sv | 65 ++++++
 rtl/key_debounce.sv | 56 +++++
 rtl/pac_dir_buffer.sv | 135 +++++++++++++
 tb/tb_pac_dir_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pac_pkg.sv
// Shared types and helpers for the player direction front end.
//   dir_t        : movement direction, encoded LEFT=0 RIGHT=1 DOWN=2 UP=3
//   key_dec_t    : decoded keycode (valid flag plus direction)
//   KEY_A/D/S/W  : canonical USB keycodes for the four directions
package pac_pkg;

    localparam int unsigned KC_W = 8;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        UP    = 2'd3
    } dir_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } pend_state_t;

    // A non-direction key always decodes with dir=LEFT so that two NONE values compare equal.
    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_dec_t;

    localparam logic [KC_W-1:0] KEY_A = 8'h04;
    localparam logic [KC_W-1:0] KEY_D = 8'h07;
    localparam logic [KC_W-1:0] KEY_S = 8'h16;
    localparam logic [KC_W-1:0] KEY_W = 8'h1A;

    // Map a raw keycode to a direction; anything unrecognised is NONE.
    function automatic key_dec_t key_to_dir(input logic [KC_W-1:0] kc);
        key_dec_t r;
        r.valid = 1'b1;
        r.dir   = LEFT;
        case (kc)
            KEY_A:   r.dir = LEFT;
            KEY_D:   r.dir = RIGHT;
            KEY_S:   r.dir = DOWN;
            KEY_W:   r.dir = UP;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // Canonical keycode presented to the motion block for a direction.
    function automatic logic [KC_W-1:0] dir_to_key(input dir_t d);
        logic [KC_W-1:0] k;
        case (d)
            LEFT:    k = KEY_A;
            RIGHT:   k = KEY_D;
            DOWN:    k = KEY_S;
            UP:      k = KEY_W;
            default: k = KEY_A;
        endcase
        return k;
    endfunction

    // Opposite direction: the encoding pairs LEFT/RIGHT and DOWN/UP on bit 0.
    function automatic dir_t dir_reverse(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-tick debouncer for decoded direction keys.
//   Clk, Reset    : clock and synchronous active-high reset
//   tick          : one-cycle frame tick; state only advances when high
//   dec           : decoded key for this cycle
//   accept_c      : combinational pulse on the tick where a direction becomes stable
//   accept_dir_c  : direction being accepted (valid only with accept_c)
module key_debounce
    import pac_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic     Clk,
    input  logic     Reset,
    input  logic     tick,
    input  key_dec_t dec,
    output logic     accept_c,
    output dir_t     accept_dir_c
);

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_FRAMES);

    key_dec_t         cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Candidate register and run-length counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cand_q <= '{valid: 1'b0, dir: LEFT};
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    // Count consecutive identical ticks; accept fires only on the tick the run reaches STABLE.
    always_comb begin
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        accept_c     = 1'b0;
        accept_dir_c = dec.dir;
        if (tick) begin
            if (dec == cand_q) begin
                if (cnt_q < STABLE) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cand_d = dec;
                cnt_d  = CNT_W'(1);
            end
            accept_c = (cnt_d == STABLE) && (cnt_q < STABLE) && cand_d.valid;
        end
    end

endmodule

// File: rtl/pac_dir_buffer.sv
// Turns raw USB keycodes into a single held direction keycode for player motion.
// Debounces over frame ticks, buffers one pending turn and commits it when the maze
// reports the turn is open, on a reversal, or when nothing has been committed yet.
//   Clk, Reset    : clock and synchronous active-high reset
//   frame_clk     : vsync-rate level, sampled on Clk
//   keycode_in    : raw keycode
//   turn_ok       : maze says pending turn is legal now (sampled on ticks only)
//   keycode_out   : held keycode for the motion block
//   dir_cur       : committed direction
//   dir_valid     : a direction has been committed since reset
//   pending_valid : a turn is buffered
//   frame_tick    : one-Clk pulse per frame_clk rising edge
module pac_dir_buffer
    import pac_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned HOLD_FRAMES   = 8,
    parameter int unsigned CNT_W         = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            frame_clk,
    input  logic [KC_W-1:0] keycode_in,
    input  logic            turn_ok,
    output logic [KC_W-1:0] keycode_out,
    output logic [1:0]      dir_cur,
    output logic            dir_valid,
    output logic            pending_valid,
    output logic            frame_tick
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

    logic [KC_W-1:0]  kc_q;
    logic             frame_prev;
    key_dec_t         dec;
    logic             accept_c;
    dir_t             accept_dir_c;

    pend_state_t      state_q, state_d;
    dir_t             pend_q, pend_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    dir_t             dir_q, dir_d;
    logic             dir_valid_d;
    logic [KC_W-1:0]  key_d;
    logic             commit_c;
    logic             take_c;

    // Input register and frame edge detect; frame_prev resets high so a high frame_clk
    // at reset release does not look like an edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            kc_q       <= '0;
            frame_prev <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            kc_q       <= keycode_in;
            frame_prev <= frame_clk;
            frame_tick <= frame_clk & ~frame_prev;
        end
    end

    assign dec = key_to_dir(kc_q);

    key_debounce #(
        .STABLE_FRAMES (STABLE_FRAMES),
        .CNT_W         (CNT_W)
    ) u_debounce (
        .Clk          (Clk),
        .Reset        (Reset),
        .tick         (frame_tick),
        .dec          (dec),
        .accept_c     (accept_c),
        .accept_dir_c (accept_dir_c)
    );

    // Pending-turn state and committed direction registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            pend_q        <= LEFT;
            hold_q        <= '0;
            dir_q         <= LEFT;
            dir_valid     <= 1'b0;
            keycode_out   <= '0;
            pending_valid <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            hold_q        <= hold_d;
            dir_q         <= dir_d;
            dir_valid     <= dir_valid_d;
            keycode_out   <= key_d;
            pending_valid <= (state_d == ST_PEND);
        end
    end

    assign dir_cur = dir_q;

    // Per tick: commit, else age/expire, then a fresh accept overrides either outcome.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        hold_d      = hold_q;
        dir_d       = dir_q;
        dir_valid_d = dir_valid;
        key_d       = keycode_out;
        commit_c    = 1'b0;
        take_c      = 1'b0;
        if (frame_tick) begin
            commit_c = (state_q == ST_PEND) &&
                       (turn_ok || !dir_valid || (pend_q == dir_reverse(dir_q)));
            if (commit_c) begin
                dir_d       = pend_q;
                dir_valid_d = 1'b1;
                key_d       = dir_to_key(pend_q);
                state_d     = ST_IDLE;
            end else if (state_q == ST_PEND) begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            // Compare against the post-commit direction so re-pressing the current way is a no-op.
            take_c = accept_c && (!dir_valid_d || (accept_dir_c != dir_d));
            if (take_c) begin
                pend_d  = accept_dir_c;
                hold_d  = '0;
                state_d = ST_PEND;
            end
        end
    end

endmodule

// File: tb/tb_pac_dir_buffer.sv
module tb_pac_dir_buffer;

    localparam int unsigned S = 2;
    localparam int unsigned H = 8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode_in;
    logic       turn_ok;
    logic [7:0] keycode_out;
    logic [1:0] dir_cur;
    logic       dir_valid;
    logic       pending_valid;
    logic       frame_tick;

    always #5 Clk = ~Clk;

    pac_dir_buffer #(
        .STABLE_FRAMES (S),
        .HOLD_FRAMES   (H),
        .CNT_W         (4)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .keycode_in    (keycode_in),
        .turn_ok       (turn_ok),
        .keycode_out   (keycode_out),
        .dir_cur       (dir_cur),
        .dir_valid     (dir_valid),
        .pending_valid (pending_valid),
        .frame_tick    (frame_tick)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-tick history of decoded keys, pending turn with an age.
    int         hist[$];
    bit         m_pend;
    int         m_pdir;
    int         m_age;
    int         m_dir;
    bit         m_valid;
    logic [7:0] m_key;
    bit         exp_tick;
    bit         chk_en = 1'b0;

    function automatic int decode(input logic [7:0] k);
        case (k)
            8'h04:   return 0;
            8'h07:   return 1;
            8'h16:   return 2;
            8'h1A:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] key_of(input int d);
        case (d)
            0:       return 8'h04;
            1:       return 8'h07;
            2:       return 8'h16;
            default: return 8'h1A;
        endcase
    endfunction

    function automatic int opposite(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_pend   = 1'b0;
        m_pdir   = 0;
        m_age    = 0;
        m_dir    = 0;
        m_valid  = 1'b0;
        m_key    = 8'h00;
        exp_tick = 1'b0;
    endtask

    task automatic model_tick(input logic [7:0] key, input bit ok);
        int  d;
        int  n;
        bit  acc;
        d = decode(key);
        hist.push_back(d);
        n = hist.size();
        // Accept when the last S ticks all show the same real direction and the run is exactly S long.
        acc = (d >= 0) && (n >= S);
        if (acc) begin
            for (int i = 1; i <= S; i++) if (hist[n-i] != d) acc = 1'b0;
            if (acc && n > S && hist[n-1-S] == d) acc = 1'b0;
        end
        if (m_pend && (ok || !m_valid || m_pdir == opposite(m_dir))) begin
            m_dir   = m_pdir;
            m_valid = 1'b1;
            m_key   = key_of(m_pdir);
            m_pend  = 1'b0;
        end else if (m_pend) begin
            m_age++;
            if (m_age >= H) m_pend = 1'b0;
        end
        if (acc && (!m_valid || d != m_dir)) begin
            m_pend = 1'b1;
            m_pdir = d;
            m_age  = 0;
        end
    endtask

    // Compare process: every cycle, just after the active edge.
    always @(posedge Clk) begin
        #1;
        if (chk_en) begin
            check("cyc_keycode_out",   keycode_out,           m_key);
            check("cyc_dir_cur",       8'(dir_cur),           8'(m_dir));
            check("cyc_dir_valid",     8'(dir_valid),         8'(m_valid));
            check("cyc_pending_valid", 8'(pending_valid),     8'(m_pend));
            check("cyc_frame_tick",    8'(frame_tick),        8'(exp_tick));
        end
    end

    // One frame: key/turn_ok settle, frame_clk rises, model advances between the two DUT edges.
    task automatic do_tick(input logic [7:0] key, input bit ok);
        @(negedge Clk);
        keycode_in = key;
        turn_ok    = ok;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b1;
        exp_tick  = 1'b1;
        @(negedge Clk);
        model_tick(key, ok);
        exp_tick = 1'b0;
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    logic [7:0] toggles[8];

    initial begin
        Reset      = 1'b1;
        frame_clk  = 1'b1;
        keycode_in = 8'h00;
        turn_ok    = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        // frame_clk stays high across reset release: no tick may appear
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);

        // Idle with no key
        for (int i = 0; i < 10; i++) do_tick(8'h00, 1'b0);
        check("idle_keycode",  keycode_out,        8'h00);
        check("idle_dvalid",   8'(dir_valid),      8'h00);
        check("idle_pending",  8'(pending_valid),  8'h00);

        // First direction commits without turn_ok
        do_tick(8'h07, 1'b0);
        do_tick(8'h07, 1'b0);
        check("first_pend",    8'(pending_valid),  8'h01);
        check("first_nodir",   8'(dir_valid),      8'h00);
        do_tick(8'h07, 1'b0);
        check("first_key",     keycode_out,        8'h07);
        check("first_dir",     8'(dir_cur),        8'h01);

        // Buffered DOWN survives key release, commits on turn_ok
        do_tick(8'h16, 1'b0);
        do_tick(8'h16, 1'b0);
        do_tick(8'h16, 1'b0);
        for (int i = 0; i < 3; i++) do_tick(8'h00, 1'b0);
        check("buf_pend",      8'(pending_valid),  8'h01);
        check("buf_key_old",   keycode_out,        8'h07);
        do_tick(8'h00, 1'b1);
        check("buf_key",       keycode_out,        8'h16);
        check("buf_dir",       8'(dir_cur),        8'h02);

        // Back to RIGHT
        do_tick(8'h07, 1'b0);
        do_tick(8'h07, 1'b0);
        do_tick(8'h07, 1'b1);
        do_tick(8'h00, 1'b0);
        check("right_key",     keycode_out,        8'h07);

        // Pending DOWN expires after HOLD ticks without turn_ok
        for (int i = 0; i < 9; i++) do_tick(8'h16, 1'b0);
        check("exp_still",     8'(pending_valid),  8'h01);
        do_tick(8'h16, 1'b0);
        check("exp_drop",      8'(pending_valid),  8'h00);
        check("exp_key",       keycode_out,        8'h07);

        // Reversal commits on the tick after accept
        do_tick(8'h04, 1'b0);
        do_tick(8'h04, 1'b0);
        check("rev_pend",      8'(pending_valid),  8'h01);
        do_tick(8'h04, 1'b0);
        check("rev_key",       keycode_out,        8'h04);
        check("rev_dir",       8'(dir_cur),        8'h00);
        do_tick(8'h00, 1'b0);

        // Chatter never settles
        toggles = '{8'h1A, 8'h16, 8'h1A, 8'h16, 8'h2C, 8'h1A, 8'h16, 8'h1A};
        for (int i = 0; i < 8; i++) do_tick(toggles[i], 1'b0);
        do_tick(8'h00, 1'b0);
        check("tog_pend",      8'(pending_valid),  8'h00);
        check("tog_key",       keycode_out,        8'h04);

        // Reset while a turn is pending
        do_tick(8'h1A, 1'b0);
        do_tick(8'h1A, 1'b0);
        check("rst_pre_pend",  8'(pending_valid),  8'h01);
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        @(negedge Clk);
        check("rst_key",       keycode_out,        8'h00);
        check("rst_dvalid",    8'(dir_valid),      8'h00);
        check("rst_pend",      8'(pending_valid),  8'h00);
        check("rst_dir",       8'(dir_cur),        8'h00);
        Reset = 1'b0;
        do_tick(8'h00, 1'b0);
        do_tick(8'h00, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
